// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared pipeline bundle widths, field offsets and stage-state type
package pipe_stage_reg_pkg;
  localparam int IFID_W  = 32;
  localparam int IDEX_W  = 76;
  localparam int EXMEM_W = 73;
  localparam int MEMWB_W = 38;
  localparam int IFID_PC_MSB    = 31, IFID_PC_LSB    = 16;
  localparam int IFID_INSTR_MSB = 15, IFID_INSTR_LSB = 0;
  localparam int IDEX_CTRL_MSB  = 75, IDEX_CTRL_LSB  = 70;
  localparam int IDEX_PC_MSB    = 69, IDEX_PC_LSB    = 54;
  localparam int IDEX_RS_MSB    = 53, IDEX_RS_LSB    = 38;
  localparam int IDEX_RT_MSB    = 37, IDEX_RT_LSB    = 22;
  localparam int IDEX_IMM_MSB   = 21, IDEX_IMM_LSB   = 6;
  localparam int IDEX_RD_MSB    = 5,  IDEX_RD_LSB    = 3;
  localparam int IDEX_RTN_MSB   = 2,  IDEX_RTN_LSB   = 0;
  localparam int EXMEM_CTRL_MSB    = 72, EXMEM_CTRL_LSB    = 68;
  localparam int EXMEM_RESULT_MSB  = 67, EXMEM_RESULT_LSB  = 52;
  localparam int EXMEM_ZERO        = 51;
  localparam int EXMEM_DATA_MSB    = 50, EXMEM_DATA_LSB    = 35;
  localparam int EXMEM_MEMADDR_MSB = 34, EXMEM_MEMADDR_LSB = 19;
  localparam int EXMEM_JEQADDR_MSB = 18, EXMEM_JEQADDR_LSB = 3;
  localparam int EXMEM_REG1_MSB    = 2,  EXMEM_REG1_LSB    = 0;
  localparam int MEMWB_CTRL_MSB   = 37, MEMWB_CTRL_LSB   = 35;
  localparam int MEMWB_MEM_MSB    = 34, MEMWB_MEM_LSB    = 19;
  localparam int MEMWB_RESULT_MSB = 18, MEMWB_RESULT_LSB = 3;
  localparam int MEMWB_REG_MSB    = 2,  MEMWB_REG_LSB    = 0;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} stage_state_e;
  function automatic logic [1:0] count_of(stage_state_e s);
    return s == TWO ? 2'd2 : s == ONE ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid entry and flush
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH = EXMEM_W,
  parameter bit SKID = 1'b1,
  parameter bit CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [1:0]       Count
);
  stage_state_e state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic in_fire, out_fire;
  assign OutValid = state_q != EMPTY;
  assign OutData = main_q;
  assign Count = count_of(state_q);
  assign in_fire = InValid && InReady;
  assign out_fire = OutValid && OutReady;
  // handshake transitions; the skid entry is always younger than main, flush overrides everything
  always_comb begin
    state_d = state_q;
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: begin
        state_d = in_fire ? ONE : EMPTY;
        main_d = in_fire ? InData : main_q;
      end
      ONE: begin
        state_d = out_fire ? (in_fire ? ONE : EMPTY) : (in_fire ? TWO : ONE);
        main_d = (in_fire && out_fire) ? InData : main_q;
        skid_d = (in_fire && !out_fire) ? InData : skid_q;
      end
      TWO: begin
        state_d = out_fire ? ONE : TWO;
        main_d = out_fire ? skid_q : main_q;
      end
      default: state_d = EMPTY;
    endcase
    if (Flush) begin
      state_d = EMPTY;
      main_d = CLEAR_ON_FLUSH ? '0 : main_q;
      skid_d = CLEAR_ON_FLUSH ? '0 : skid_q;
    end
  end
  // state and main entry; reset takes priority over flush
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= EMPTY;
      main_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
    end
  end
  generate
    if (SKID) begin : g_skid
      logic in_ready_q, in_ready_d;
      // ready is registered from the next state so no OutReady path reaches InReady
      always_comb in_ready_d = state_d != TWO;
      // skid entry and registered ready
      always_ff @(posedge Clk) begin
        if (!Reset_n) begin
          skid_q <= '0;
          in_ready_q <= 1'b1;
        end else begin
          skid_q <= skid_d;
          in_ready_q <= in_ready_d;
        end
      end
      assign InReady = Reset_n && in_ready_q;
    end else begin : g_noskid
      assign skid_q = '0;
      assign InReady = Reset_n && (!OutValid || OutReady);
    end
  endgenerate
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three configurations checked against a queue-based stage model
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;
  localparam int W = EXMEM_W;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready [3];
  logic out_valid [3];
  logic [W-1:0] out_data [3];
  logic [1:0] count [3];
  logic [W-1:0] mq [3][$];
  logic [W-1:0] mon [3][$];
  logic [W-1:0] hold [3];
  int tests = 0, fails = 0;

  pipe_stage_reg #(.WIDTH(W), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1)) dut0 (
    .Clk(clk), .Reset_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(in_ready[0]),
    .InData(in_data), .OutValid(out_valid[0]), .OutReady(out_ready), .OutData(out_data[0]), .Count(count[0]));
  pipe_stage_reg #(.WIDTH(W), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b0)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(in_ready[1]),
    .InData(in_data), .OutValid(out_valid[1]), .OutReady(out_ready), .OutData(out_data[1]), .Count(count[1]));
  pipe_stage_reg #(.WIDTH(W), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b1)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .Flush(flush), .InValid(in_valid), .InReady(in_ready[2]),
    .InData(in_data), .OutValid(out_valid[2]), .OutReady(out_ready), .OutData(out_data[2]), .Count(count[2]));

  always #5 clk = ~clk;

  function automatic bit sk(int i);
    return i != 2;
  endfunction

  function automatic bit cl(int i);
    return i != 1;
  endfunction

  function automatic logic mready(int i);
    if (!rst_n) return 1'b0;
    return sk(i) ? (mq[i].size() < 2) : (mq[i].size() == 0 || out_ready);
  endfunction

  task automatic tick();
    logic inf [3];
    logic outf [3];
    for (int i = 0; i < 3; i++) begin
      inf[i] = in_valid && mready(i);
      outf[i] = mq[i].size() > 0 && out_ready;
      if (rst_n && out_valid[i] && out_ready) mon[i].push_back(out_data[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        hold[i] = '0;
      end else if (flush) begin
        mq[i].delete();
        if (cl(i)) hold[i] = '0;
      end else begin
        if (outf[i]) void'(mq[i].pop_front());
        if (inf[i]) mq[i].push_back(in_data);
        if (mq[i].size() > 0) hold[i] = mq[i][0];
      end
    end
    #1;
  endtask

  task automatic clean();
    flush = 1'b1;
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) mon[i].delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = W'(32'h12345);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (out_valid[i] !== 1'b0 || out_data[i] !== '0 || count[i] !== 2'd0 || in_ready[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset inst%0d: valid=%b data=%h count=%0d rdy=%b, required 0 0 0 0", i, out_valid[i], out_data[i], count[i], in_ready[i]);
      end
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (in_ready[i] !== 1'b1) begin
        fails++;
        $display("FAIL reset_release inst%0d: rdy=%b, required 1", i, in_ready[i]);
      end
    end
  endtask

  task automatic test_streaming();
    clean();
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1;
      in_data = W'(k);
      tick();
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (out_valid[i] !== 1'b1 || out_data[i] !== W'(k)) begin
          fails++;
          $display("FAIL stream inst%0d k=%0d: valid=%b data=%h, required 1 %h", i, k, out_valid[i], out_data[i], W'(k));
        end
      end
    end
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bit bad;
      bad = mon[i].size() != 16 || out_valid[i] !== 1'b0;
      if (!bad) for (int k = 0; k < 16; k++) if (mon[i][k] !== W'(k + 1)) bad = 1'b1;
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL stream_order inst%0d: %0d transfers valid=%b, required 16 in order 1..16 then valid=0", i, mon[i].size(), out_valid[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clean();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = W'(32'hA0);
    tick();
    out_ready = 1'b0;
    in_data = W'(32'hA1);
    #1;
    tests++;
    if (in_ready[0] !== 1'b1 || in_ready[2] !== 1'b0) begin
      fails++;
      $display("FAIL bp_ready: skid rdy=%b noskid rdy=%b, required 1 0", in_ready[0], in_ready[2]);
    end
    tick();
    tests++;
    if (count[0] !== 2'd2 || in_ready[0] !== 1'b0 || out_data[0] !== W'(32'hA0)) begin
      fails++;
      $display("FAIL bp_skid: count=%0d rdy=%b data=%h, required 2 0 a0", count[0], in_ready[0], out_data[0]);
    end
    in_data = W'(32'hA2);
    tick();
    tests++;
    if (count[0] !== 2'd2 || out_data[0] !== W'(32'hA0) || out_valid[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_stable: count=%0d data=%h valid=%b, required 2 a0 1", count[0], out_data[0], out_valid[0]);
    end
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tests++;
    if (mon[0].size() != 3 || mon[0][0] !== W'(32'hA0) || mon[0][1] !== W'(32'hA1) || mon[0][2] !== W'(32'hA2)) begin
      fails++;
      $display("FAIL bp_order: %0d transfers, required a0 a1 a2", mon[0].size());
    end
  endtask

  task automatic test_flush();
    clean();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(32'h11);
    tick();
    in_data = W'(32'h22);
    tick();
    tests++;
    if (count[0] !== 2'd2 || count[1] !== 2'd2) begin
      fails++;
      $display("FAIL flush_pre: counts %0d %0d, required 2 2", count[0], count[1]);
    end
    flush = 1'b1;
    in_data = W'(32'hBB);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (out_valid[i] !== 1'b0 || count[i] !== 2'd0 || out_data[i] !== (i == 1 ? W'(32'h11) : W'(0))) begin
        fails++;
        $display("FAIL flush inst%0d: valid=%b count=%0d data=%h, required 0 0 %h", i, out_valid[i], count[i], out_data[i], i == 1 ? W'(32'h11) : W'(0));
      end
    end
    out_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (mon[i].size() != 0) begin
        fails++;
        $display("FAIL flush_drop inst%0d: %0d transfers after flush, required 0", i, mon[i].size());
      end
    end
  endtask

  task automatic test_skid0();
    clean();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(32'h44);
    tick();
    tests++;
    if (in_ready[2] !== 1'b0 || out_valid[2] !== 1'b1) begin
      fails++;
      $display("FAIL skid0_stall: rdy=%b valid=%b, required 0 1", in_ready[2], out_valid[2]);
    end
    out_ready = 1'b1;
    in_data = W'(32'h55);
    #1;
    tests++;
    if (in_ready[2] !== 1'b1) begin
      fails++;
      $display("FAIL skid0_comb_ready: rdy=%b, required 1", in_ready[2]);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_data[2] !== W'(32'h55) || out_valid[2] !== 1'b1 || count[2] !== 2'd1) begin
      fails++;
      $display("FAIL skid0_replace: data=%h valid=%b count=%0d, required 55 1 1", out_data[2], out_valid[2], count[2]);
    end
  endtask

  task automatic test_flush_transfer();
    clean();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'(32'hC3);
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (mon[i].size() != 1 || mon[i][0] !== W'(32'hC3) || count[i] !== 2'd0 || out_valid[i] !== 1'b0) begin
        fails++;
        $display("FAIL flush_xfer inst%0d: %0d transfers count=%0d valid=%b, required one c3 then empty", i, mon[i].size(), count[i], out_valid[i]);
      end
    end
  endtask

  task automatic test_random();
    clean();
    for (int c = 0; c < 500; c++) begin
      rst_n = $urandom_range(0, 59) != 0;
      flush = $urandom_range(0, 24) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      in_data = W'({$urandom(), $urandom(), $urandom()});
      #1;
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (out_valid[i] !== (mq[i].size() > 0) || count[i] !== 2'(mq[i].size()) || out_data[i] !== hold[i] || in_ready[i] !== mready(i)) begin
          fails++;
          $display("FAIL rand[%0d] inst%0d: valid=%b count=%0d data=%h rdy=%b, required %b %0d %h %b", c, i,
            out_valid[i], count[i], out_data[i], in_ready[i], mq[i].size() > 0, mq[i].size(), hold[i], mready(i));
        end
      end
      tick();
    end
    rst_n = 1'b1;
    flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) hold[i] = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0();
    test_flush_transfer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the general successor to the fixed-width stage latches between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload with a valid/ready handshake and an optional two-entry skid buffer. It also supports synchronous flush with selectable payload clearing. Every inter-stage boundary in the pipeline instantiates this block, so stalls propagate without combinational ready paths spanning stages.

## Interface
Parameters:
- WIDTH, 73, payload width in bits (packed stage bundle).
- SKID, 1, 1 = two-entry skid buffer with registered InReady; 0 = single entry, combinational InReady.
- CLEAR_ON_FLUSH, 1, 1 = payload registers zeroed on flush; 0 = only valid bits cleared.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Flush  in  1  synchronous flush (branch/JEQ redirect); discards all held entries.
- InValid  in  1  upstream has payload.
- InReady  out  1  stage can accept this cycle.
- InData  in  WIDTH  upstream payload.
- OutValid  out  1  OutData is valid.
- OutReady  in  1  downstream accepts this cycle.
- OutData  out  WIDTH  payload to next stage.
- Count  out  2  entries held (0..2; never exceeds 1 when SKID=0).

## Operation
- Transfer in: InValid && InReady at the rising edge. Transfer out: OutValid && OutReady at the rising edge.
- States are EMPTY (Count=0), ONE (main entry valid), and TWO (main + skid valid; SKID=1 only).
- EMPTY: in → ONE.
- ONE:
  - in && out → ONE, main loads InData.
  - out only → EMPTY.
  - in only → TWO (SKID=1), with skid loading InData. With SKID=0 this case cannot occur, because InReady=0.
- TWO:
  - out → ONE, main loads skid.
  - No input is accepted in TWO.
- InReady:
  - SKID=1: InReady = !skid_valid, driven by a register with no combinational path from OutReady.
  - SKID=0: InReady = !OutValid || OutReady.
- Ordering is strictly FIFO: the skid entry is always younger than the main entry.
- Flush: next state is EMPTY regardless of In/Out activity. Any input presented in the flush cycle is discarded. OutData becomes 0 if CLEAR_ON_FLUSH=1; otherwise it holds its stale value with OutValid=0.
- Priority: Reset_n low > Flush > normal handshake.
- OutData is always the main entry register and does not change while OutValid && !OutReady (stability rule).

## Timing
- Latency is 1 cycle: data accepted at edge N appears on OutData after edge N, if the stage was empty or draining.
- Throughput is 1 transfer/cycle in steady state for both SKID values.
- SKID=1: after OutReady drops, at most one further input is accepted (into skid). InReady falls the cycle after that acceptance.
- Reset (Reset_n low at edge): OutValid=0, OutData=0, Count=0, skid cleared. InReady is forced 0 combinationally while Reset_n=0, and is 1 on the first cycle after reset deassertion.
- Reset asserted mid-stream drops both entries with no partial transfer. Reset is checked before Flush.
- Simultaneous Flush && OutReady && OutValid: the downstream transfer counts as taken, since downstream sampled it. The stage still ends EMPTY.
- Count is registered and updates on the same edge as the state.

## Structure
- The shared pipeline package holds:
  - stage bundle widths as constants (IFID_W, IDEX_W, EXMEM_W=73, MEMWB_W);
  - field offset constants for each bundle, e.g. EXMEM control [72:68], result [67:52], zero [51], data [50:35], memaddr [34:19], jeqaddr [18:3], reg1 [2:0];
  - a stage-state enum {EMPTY, ONE, TWO}.
- No sub-module. Skid and main registers live in one module under generate on SKID.
- Bundle packing/unpacking is done by instantiating stages, not inside this block.

## Test plan
- Reset: hold Reset_n=0 for 2 cycles with InValid=1, InData=0x1_2345 → OutValid=0, OutData=0, Count=0, InReady=0. One cycle after release, InReady=1.
- Streaming (SKID=1, OutReady=1): send 0x01..0x10 back-to-back → same sequence on OutData, one per cycle, 1-cycle latency, no gaps.
- Backpressure (SKID=1): stream 0xA0, 0xA1, 0xA2 and drop OutReady after 0xA0 is presented.
  - Required: 0xA0 holds stable, 0xA1 goes into skid, Count=2, InReady=0 next cycle, 0xA2 is held upstream.
  - On OutReady=1, the order is 0xA0, 0xA1, 0xA2.
- Flush with Count=2 and InValid=1 (0xBB):
  - Next cycle: OutValid=0, Count=0, 0xBB not delivered.
  - OutData=0 when CLEAR_ON_FLUSH=1; OutData keeps the old value when CLEAR_ON_FLUSH=0.
- SKID=0 backpressure: OutValid=1, OutReady=0 → InReady=0 in the same cycle. Raise OutReady with InValid=1, 0x55 → accept-and-replace, OutData=0x55 next cycle.
- Simultaneous Flush && OutValid && OutReady with payload 0xC3 → the monitor records a single 0xC3 transfer, and the stage is EMPTY afterwards.
